// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, default device
// address and the R/W bit values used by both master and responder.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUBADDR,
        ST_SUBADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } sccb_state_e;

    localparam logic [6:0] SCCB_DEV_ADDR_DEF = 7'h21;

    // Value of bit 0 of the address byte
    localparam logic SCCB_RW_WRITE = 1'b0;
    localparam logic SCCB_RW_READ  = 1'b1;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizer plus edge detector for one bus line. Flops reset to 1
// (the idle level of an open-drain bus) so that leaving reset produces
// no spurious edges.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain and one extra flop holding the previous sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= line_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign line_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB responder: answers to DEV_ADDR, supports 3-phase writes
// (addr, sub-addr, data), 2-phase writes (addr, sub-addr) that only set
// the sub-address, and 2-phase reads that return data for the stored
// sub-address. sda is only ever pulled low or released.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = SCCB_DEV_ADDR_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_io,
    inout  wire        sda_io,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    sccb_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sda_oe_q, sda_oe_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic        reg_re_q, reg_re_d;
    logic        load_q, load_d;

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    logic start_w, stop_w;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (scl_io),
        .line_o (scl_s),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (sda_io),
        .line_o (sda_s),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // sda edges while scl is high are bus conditions, never data
    assign start_w = sda_fall & scl_s;
    assign stop_w  = sda_rise & scl_s;

    // Open-drain driver; the enable flop resets asynchronously so a reset
    // releases the line immediately
    assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: START/STOP override everything; otherwise bytes end on
    // the 8th scl rise and ACK slots end on the 9th scl rise
    always_comb begin
        state_d = state_q;
        if (stop_w) begin
            state_d = ST_IDLE;
        end else if (start_w) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:
                    if (scl_rise && cnt_q == 3'd7)
                        state_d = (shift_q[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK:
                    if (scl_rise)
                        state_d = (shift_q[0] == SCCB_RW_READ) ? ST_RDATA : ST_SUBADDR;
                ST_SUBADDR:
                    if (scl_rise && cnt_q == 3'd7) state_d = ST_SUBADDR_ACK;
                ST_SUBADDR_ACK:
                    if (scl_rise) state_d = ST_WDATA;
                ST_WDATA:
                    if (scl_rise && cnt_q == 3'd7) state_d = ST_WDATA_ACK;
                ST_WDATA_ACK:
                    if (scl_rise) state_d = ST_WAIT_STOP;
                ST_RDATA:
                    if (scl_rise && cnt_q == 3'd7) state_d = ST_RDATA_ACK;
                ST_RDATA_ACK:
                    if (scl_rise) state_d = ST_WAIT_STOP;
                default: ;
            endcase
        end
    end

    // Outputs and datapath next values. sda only changes on an scl fall
    // (or on START/STOP, which always release it). RDATA is entered on the
    // ACK's high phase, so read data is loaded before the fall that ends
    // the ACK, and that same fall puts the MSB on the line.
    always_comb begin
        sda_oe_d    = sda_oe_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = (state_d == ST_RDATA) && (state_q != ST_RDATA);
        load_d      = reg_re_q;
        busy        = (state_q != ST_IDLE);

        if (start_w || stop_w) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUBADDR, ST_WDATA: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7 && state_q == ST_SUBADDR)
                            reg_addr_d = {shift_q[6:0], sda_s};
                        if (cnt_q == 3'd7 && state_q == ST_WDATA) begin
                            reg_wdata_d = {shift_q[6:0], sda_s};
                            reg_we_d    = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_SUBADDR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                    if (scl_rise) cnt_d = cnt_q + 3'd1;
                end
                ST_RDATA_ACK, ST_WAIT_STOP: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                default: ;
            endcase
            if (load_q) shift_d = reg_rdata;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= 8'h00;
            cnt_q       <= 3'd0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            load_q      <= load_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;

endmodule

// File: doc/sccb_responder.md
SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h21, giving the 7-bit device address this block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for scl_io and sda_io.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port scl_io, input, 1 bit: the bus clock. The block only samples it and never drives it.
REQ-006 SHALL have port sda_io, inout, 1 bit: the open-drain data line. The block drives 1'b0 or 1'bz, never 1'b1.
REQ-007 SHALL have port reg_addr, output, 8 bits: the stored sub-address.
REQ-008 SHALL have port reg_wdata, output, 8 bits: the received write data.
REQ-009 SHALL have port reg_we, output, 1 bit: a one-cycle write strobe.
REQ-010 SHALL have port reg_re, output, 1 bit: a one-cycle read strobe.
REQ-011 SHALL have port reg_rdata, input, 8 bits: read data, valid on the cycle after reg_re.
REQ-012 SHALL have port busy, output, 1 bit: high from START detection until STOP or return to IDLE.

Function
REQ-013 SHALL synchronize scl_io and sda_io through SYNC_STAGES flops, then derive scl_rise, scl_fall, start and stop one-cycle pulses from the synchronized lines.
- start: sda falls while scl is high.
- stop: sda rises while scl is high.
REQ-014 SHALL require a clk frequency of at least 16x the SCL frequency. Operation below that ratio is unspecified.
REQ-015 SHALL implement the state machine IDLE, ADDR, ADDR_ACK, SUBADDR, SUBADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-016 SHALL sample bits MSB-first on scl_rise, using an 8-bit shift register and a 3-bit bit counter.
REQ-017 SHALL change the sda_io drive only on the cycle after scl_fall.
REQ-018 In ADDR, after the 8th bit:
- bits[7:1]==DEV_ADDR: go to ADDR_ACK.
- otherwise: go to WAIT_STOP with sda released (no ACK).
REQ-019 In each *_ACK state owned by the responder, SHALL drive sda low for exactly one SCL high period, then release sda on the following scl_fall.
REQ-020 After ADDR_ACK:
- R/W bit = 0: go to SUBADDR.
- R/W bit = 1: go to RDATA.
REQ-021 SUBADDR SHALL latch the byte into reg_addr at the 8th scl_rise, then go to SUBADDR_ACK, then to WDATA.
- A STOP at this point ends a 2-phase write: reg_addr keeps its value and reg_we is not asserted.
REQ-022 WDATA SHALL load reg_wdata and pulse reg_we for one cycle at the 8th scl_rise, then go to WDATA_ACK, then to WAIT_STOP.
- Extra bytes after this point are not acknowledged.
REQ-023 On entering RDATA, SHALL pulse reg_re. It SHALL load reg_rdata into the shift register on the next cycle, before the first scl_fall of the byte.
REQ-024 In RDATA, SHALL shift the byte out MSB-first, setting sda on each scl_fall.
REQ-025 After the 8th bit of RDATA, SHALL release sda and sample the master's bit in RDATA_ACK. ACK and NACK are both accepted, and the next state is WAIT_STOP.
REQ-026 A start pulse in any state, including a repeated START, SHALL release sda, clear the bit counter and enter ADDR.
REQ-027 A stop pulse in any state SHALL release sda and enter IDLE.
REQ-028 reg_addr SHALL persist across transactions, so that a 2-phase read returns data from the last written sub-address.

Reset
REQ-029 Reset SHALL put the state machine in IDLE, release sda_io to z, and clear reg_addr, reg_wdata, reg_we, reg_re, busy, the shift register, the bit counter, and the synchronizers (to 1).
REQ-030 Reset asserted mid-byte SHALL release sda within the same cycle (asynchronous path). After deassertion, the block SHALL ignore the bus until the next START.

Structure
REQ-031 Package sccb_pkg SHALL hold:
- the state enum;
- the DEV_ADDR default;
- the R/W bit constants, shared with the SCCB master.
REQ-032 Sub-module sccb_line_sync SHALL contain the synchronizer and edge detector, instantiated once per line.

Verification
REQ-033 3-phase write 0x42, 0x12, 0x80 -> ACK on every byte; reg_we pulses once with reg_addr=0x12 and reg_wdata=0x80; busy falls after STOP.
REQ-034 2-phase write 0x42, 0x0A, then 2-phase read 0x43 with reg_rdata=0x76 -> reg_re pulses once; bits 0,1,1,1,0,1,1,0 appear on sda; the master's NACK is accepted and the block returns to IDLE.
REQ-035 Address byte 0x60 -> no ACK (sda stays z through the 9th clock); reg_we and reg_re stay low; the block waits for STOP.
REQ-036 Repeated START after the sub-address byte 0x1C, followed by 0x43 -> enters RDATA with reg_addr=0x1C and no reg_we.
REQ-037 rst asserted while the block is driving an ACK -> sda is z in the same cycle; a subsequent valid write completes normally.
REQ-038 STOP injected after 4 bits of the data byte -> IDLE; reg_we never pulses; reg_addr is unchanged.
